// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_pkg
//  Description : Shared constants for the arcade input controller: PS/2 key
//                codes as 9-bit {extended, scancode}, held-key and CSJUDLR
//                bit positions, sequencer state encoding and the
//                orientation remap helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

    // PS/2 codes, {extended, scancode}
    localparam logic [8:0] c_key_up         = 9'h175;
    localparam logic [8:0] c_key_down       = 9'h172;
    localparam logic [8:0] c_key_left       = 9'h16B;
    localparam logic [8:0] c_key_right      = 9'h174;
    localparam logic [8:0] c_key_fire_space = 9'h029;
    localparam logic [8:0] c_key_fire_ctrl  = 9'h014;
    localparam logic [8:0] c_key_start1     = 9'h005;
    localparam logic [8:0] c_key_start2     = 9'h006;
    localparam logic [8:0] c_key_coin       = 9'h02E;

    // Held-key vector positions; identical to the joystick bit layout so the
    // two can be OR-ed directly.
    localparam int c_hk_right  = 0;
    localparam int c_hk_left   = 1;
    localparam int c_hk_down   = 2;
    localparam int c_hk_up     = 3;
    localparam int c_hk_fire   = 4;
    localparam int c_hk_start1 = 5;
    localparam int c_hk_start2 = 6;
    localparam int c_hk_coin   = 7;

    // CSJUDLR output positions
    localparam int c_out_right = 0;
    localparam int c_out_left  = 1;
    localparam int c_out_down  = 2;
    localparam int c_out_up    = 3;
    localparam int c_out_fire  = 4;
    localparam int c_out_start = 5;
    localparam int c_out_coin  = 6;

    // Coin/start sequencer states
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t c_seq_idle  = 2'd0;
    localparam seq_state_t c_seq_coin  = 2'd1;
    localparam seq_state_t c_seq_gap   = 2'd2;
    localparam seq_state_t c_seq_start = 2'd3;

    // Input and result are {up, down, left, right}. In horizontal mode the
    // cabinet is rotated, so each physical direction drives its neighbour.
    function automatic logic [3:0] remap_udlr(input logic [3:0] udlr,
                                              input logic       rotate);
        logic [3:0] r;
        r = udlr;
        if (rotate) begin
            r = {udlr[1], udlr[0], udlr[2], udlr[3]};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_latch.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_latch
//  Description : Detects PS/2 event strobes (toggle of bit 10), decodes the
//                game keys and keeps one held/released flag per key.
//  Ports       : clk_sys      - system clock
//                RESET        - synchronous active-high reset
//                i_ps2_key    - [10] toggle, [9] pressed, [8] ext, [7:0] code
//                o_key_held   - held flags in joystick layout
//                               {coin, start2, start1, fire, U, D, L, R}
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_latch
    import arcade_input_pkg::*;
(
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] i_ps2_key,
    output logic [7:0]  o_key_held
);

    logic       r_old_toggle;
    logic [7:0] r_key_held;
    logic       w_event;
    logic [7:0] w_hit;

    assign w_event = (r_old_toggle != i_ps2_key[10]);

    // One-hot target of the presented code; unknown codes select nothing.
    always_comb begin
        w_hit = '0;
        case (i_ps2_key[8:0])
            c_key_up:         w_hit[c_hk_up]     = 1'b1;
            c_key_down:       w_hit[c_hk_down]   = 1'b1;
            c_key_left:       w_hit[c_hk_left]   = 1'b1;
            c_key_right:      w_hit[c_hk_right]  = 1'b1;
            c_key_fire_space,
            c_key_fire_ctrl:  w_hit[c_hk_fire]   = 1'b1;
            c_key_start1:     w_hit[c_hk_start1] = 1'b1;
            c_key_start2:     w_hit[c_hk_start2] = 1'b1;
            c_key_coin:       w_hit[c_hk_coin]   = 1'b1;
            default:          w_hit = '0;
        endcase
    end

    // Old toggle is loaded from the live input during reset so a strobe that
    // happened before reset released is not replayed as a fresh event.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_old_toggle <= i_ps2_key[10];
            r_key_held   <= '0;
        end else begin
            r_old_toggle <= i_ps2_key[10];
            if (w_event) begin
                r_key_held <= (r_key_held & ~w_hit) | (w_hit & {8{i_ps2_key[9]}});
            end
        end
    end

    assign o_key_held = r_key_held;

endmodule
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_ctrl
//  Description : Player input front end for the galaxian core. Merges PS/2
//                keys with joystick bits, applies the orientation remap and
//                turns a start press into a coin pulse, a gap and a start
//                pulse.
//  Ports       : clk_sys     - 12 MHz system clock
//                RESET       - synchronous active-high reset
//                ps2_key     - PS/2 event word from hps_io
//                joy         - OR of both joysticks, [7:0] = coin,s2,s1,F,U,D,L,R
//                orient      - 0 vertical, 1 horizontal (rotated controls)
//                P1_CSJUDLR  - registered {coin, start1, fire, U, D, L, R}
//                P2_CSJUDLR  - registered {0, start2, fire, U, D, L, R}
//                seq_busy    - registered, high while the sequencer is active
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_LEN  = 1200000,
    parameter int unsigned GAP_LEN   = 600000,
    parameter int unsigned START_LEN = 1200000,
    parameter int unsigned CNT_W     = 24
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        orient,
    output logic [6:0]  P1_CSJUDLR,
    output logic [6:0]  P2_CSJUDLR,
    output logic        seq_busy
);

    localparam logic [CNT_W-1:0] c_coin_load  = CNT_W'(COIN_LEN - 1);
    localparam logic [CNT_W-1:0] c_gap_load   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] c_start_load = CNT_W'(START_LEN - 1);

    logic [7:0]       w_key_held;
    logic [7:0]       w_raw;
    logic             w_s1;
    logic             w_s2;
    logic             r_s1_prev;
    logic             r_s2_prev;
    logic             w_s1_rise;
    logic             w_s2_rise;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_sel;          // 0 = player 1 start, 1 = player 2
    logic             w_sel_nxt;
    logic             w_sel_raw;
    logic             w_cnt_zero;
    logic             w_seq_coin;
    logic             w_seq_s1;
    logic             w_seq_s2;

    logic [6:0]       w_p1_nxt;
    logic [6:0]       w_p2_nxt;
    logic [6:0]       r_p1;
    logic [6:0]       r_p2;
    logic             r_busy;
    logic             w_unused;

    assign w_unused = ^joy[15:8];

    ps2_key_latch u_key_latch (
        .clk_sys    (clk_sys),
        .RESET      (RESET),
        .i_ps2_key  (ps2_key),
        .o_key_held (w_key_held)
    );

    assign w_raw = w_key_held | joy[7:0];

    // Start edge detect on the merged key/joystick start lines
    assign w_s1      = w_raw[c_hk_start1];
    assign w_s2      = w_raw[c_hk_start2];
    assign w_s1_rise = w_s1 & ~r_s1_prev;
    assign w_s2_rise = w_s2 & ~r_s2_prev;
    assign w_sel_raw = r_sel ? w_s2 : w_s1;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_s1_prev <= 1'b0;
            r_s2_prev <= 1'b0;
            r_state   <= c_seq_idle;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
        end else begin
            r_s1_prev <= w_s1;
            r_s2_prev <= w_s2;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sel     <= w_sel_nxt;
        end
    end

    // Counter is reloaded on every transition and holds at zero in START
    // while the player keeps the button down.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_seq_coin  = 1'b0;
        w_seq_s1    = 1'b0;
        w_seq_s2    = 1'b0;
        case (r_state)
            c_seq_idle: begin
                if (w_s1_rise || w_s2_rise) begin
                    w_state_nxt = c_seq_coin;
                    w_cnt_nxt   = c_coin_load;
                    w_sel_nxt   = ~w_s1_rise;
                end
            end
            c_seq_coin: begin
                w_seq_coin = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = c_seq_gap;
                    w_cnt_nxt   = c_gap_load;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            c_seq_gap: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_seq_start;
                    w_cnt_nxt   = c_start_load;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            c_seq_start: begin
                w_seq_s1 = ~r_sel;
                w_seq_s2 = r_sel;
                if (w_cnt_zero) begin
                    if (!w_sel_raw) begin
                        w_state_nxt = c_seq_idle;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_seq_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The keyboard belongs to player 1; player 2 only sees the joystick
    // lines. The direct coin key/button bypasses the sequencer.
    always_comb begin
        w_p1_nxt = '0;
        w_p2_nxt = '0;
        w_p1_nxt[c_out_up:c_out_right] = remap_udlr(w_raw[c_hk_up:c_hk_right], orient);
        w_p1_nxt[c_out_fire]  = w_raw[c_hk_fire];
        w_p1_nxt[c_out_start] = w_seq_s1;
        w_p1_nxt[c_out_coin]  = w_seq_coin | w_raw[c_hk_coin];
        w_p2_nxt[c_out_up:c_out_right] = remap_udlr(joy[c_hk_up:c_hk_right], orient);
        w_p2_nxt[c_out_fire]  = joy[c_hk_fire];
        w_p2_nxt[c_out_start] = w_seq_s2;
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            r_p1   <= '0;
            r_p2   <= '0;
            r_busy <= 1'b0;
        end else begin
            r_p1   <= w_p1_nxt;
            r_p2   <= w_p2_nxt;
            r_busy <= (r_state != c_seq_idle);
        end
    end

    assign P1_CSJUDLR = r_p1;
    assign P2_CSJUDLR = r_p2;
    assign seq_busy   = r_busy;

endmodule
`default_nettype wire
